ula_bus_reader: RTL
===================

Name: ula_bus_reader

Overview:
Reader/controller for the shared 8-bit ULA result bus, which is driven by tri-state operation units such as the enabled AND unit. It accepts a source-select request and drives exactly one unit's active-high EN line. After a settle period it captures the bus and returns the value over a valid/ready response channel. It is the only block that asserts the EN lines, so it guarantees no bus contention.

Parameters:
WIDTH, 8, bus and result data width
NUM_SRC, 4, number of tri-state driver units on the bus (one EN line each)
SEL_W, 2, width of the select field; NUM_SRC <= 2**SEL_W required
SETTLE, 1, cycles EN is held before capture; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
req_sel  input  SEL_W  index of the unit to read
bus_en  output  NUM_SRC  one-hot active-high EN lines to the tri-state units
bus_in  input  WIDTH  shared tri-state result bus
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  WIDTH  captured bus value
rsp_zero  output  1  rsp_data == 0
rsp_src  output  SEL_W  echo of req_sel for this response
rsp_err  output  1  req_sel >= NUM_SRC; no unit was enabled

Behaviour:
- Reset values (registered, synchronous): state=IDLE, bus_en=0, req_ready=1 from the first cycle after reset, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_src=0, rsp_err=0, settle counter=0.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready=1 and bus_en=0.
  - On req_valid&&req_ready, latch req_sel.
  - If sel < NUM_SRC, go to DRIVE and set bus_en[sel]=1 on the same edge. Load the counter with SETTLE-1.
  - If sel >= NUM_SRC, go directly to RESP with rsp_data=0, rsp_zero=1, rsp_err=1, rsp_src=sel. bus_en stays 0.
- DRIVE:
  - req_ready=0 and bus_en is held one-hot.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: capture bus_in into rsp_data, set rsp_zero=(bus_in==0), rsp_err=0, rsp_src=sel, rsp_valid=1. On the same edge, clear bus_en to 0 and go to RESP.
  - Capture happens while EN is still high.
- Latency: bus_en rises 1 edge after accept; rsp_valid rises SETTLE+1 edges after accept. With SETTLE=1 this is 2 edges.
- RESP:
  - bus_en=0 and req_ready=0.
  - rsp_valid and all rsp_* fields are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE. rsp_data retains its last value.
  - A new request is accepted at the earliest on the edge after return to IDLE.
- Contention rules:
  - popcount(bus_en) <= 1 at all times.
  - At least one cycle with bus_en=0 between any two drive windows (break-before-make), guaranteed by RESP and IDLE.
- req_sel and bus_in are ignored outside the accept edge and the capture edge respectively.
- Back-to-back throughput: one transaction per SETTLE+2 cycles when rsp_ready is held high.
- rst asserted in any state: on the next edge, all outputs take reset values and bus_en=0 immediately. The in-flight transaction is dropped with no response.
- rst overrides simultaneous req_valid or rsp_ready.

Test Plan:
1. Reset, then SETTLE=1, bench unit 0 = AND(8'hF0,8'h3C), req_sel=0 -> bus_en=4'b0001 for exactly 1 cycle. rsp_valid 2 edges after accept with rsp_data=8'h30, rsp_zero=0, rsp_src=0, rsp_err=0.
2. req_sel=3 with unit 3 driving 8'h00 and rsp_ready held low for 5 cycles -> bus_en=4'b1000 for 1 cycle, then 0. rsp_valid stays high with data 8'h00, rsp_zero=1 held stable for 5 cycles; it clears on the rsp_ready edge, and req_ready returns the next cycle.
3. NUM_SRC=3, req_sel=3 -> bus_en never asserted; rsp_valid 1 edge after accept with rsp_err=1, rsp_data=8'h00.
4. SETTLE=4, bus_in changes from 8'hAA to 8'h55 on the 3rd DRIVE cycle -> bus_en held 4 cycles; rsp_data=8'h55 (value at the last DRIVE edge).
5. Back-to-back requests sel=0,1,2 with rsp_ready=1 -> one-hot bus_en sequence 0001, 0010, 0100, each separated by at least 1 cycle of 0000. One transaction per 3 cycles. A popcount(bus_en)<=1 assertion never fails.
6. rst asserted during DRIVE (sel=2) -> next edge bus_en=0, rsp_valid=0, req_ready=1 after release. No stale response appears, and the next request (sel=1, data 8'h7E) returns 8'h7E.

Source files
------------

// File: rtl/ula_bus_reader.sv
// Sole owner of the tri-state EN lines on the shared ULA result bus: enables one unit,
// waits for the bus to settle, captures it and returns the value on a valid/ready channel.
module ula_bus_reader #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_sel,
  output logic [NUM_SRC-1:0] bus_en,
  input  logic [WIDTH-1:0]   bus_in,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_zero,
  output logic [SEL_W-1:0]   rsp_src,
  output logic               rsp_err
);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_SRC-1:0]   en_q, en_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 zero_q, zero_d;
  logic [SEL_W-1:0]     src_q, src_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    src_d   = src_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          sel_d = req_sel;
          if (32'(req_sel) < NUM_SRC) begin
            state_d = StDrive;
            en_d    = NUM_SRC'(1) << req_sel;
            cnt_d   = 4'(SETTLE - 1);
          end else begin
            // No unit exists at this index: answer at once without touching the bus.
            state_d = StResp;
            valid_d = 1'b1;
            data_d  = '0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            src_d   = req_sel;
          end
        end
      end
      StDrive: begin
        if (cnt_q == 4'd0) begin
          // Sample while EN is still high, then release the bus on the same edge.
          data_d  = bus_in;
          zero_d  = (bus_in == '0);
          err_d   = 1'b0;
          src_d   = sel_q;
          valid_d = 1'b1;
          en_d    = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign bus_en    = en_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_src   = src_q;
  assign rsp_err   = err_q;

endmodule
